fetch_pipe_ctrl: RTL and testbench
==================================

# fetch_pipe_ctrl

Owns the PC register, the IF/ID pipeline register and the ID/EX control register of the 5-stage RISC-V pipeline. It is the consumer of the load-use hazard controls (`pcWrite`, `write_IFID`, `mux_IDEX`) and of the EX-stage branch redirect. It applies stalls, bubbles and flushes to the front of the pipe. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `XLEN`, 32, PC and address width
- `RESET_PC`, 0, PC value after reset
- `CTRL_W`, 8, width of the decoded control bundle carried into ID/EX
- `CNT_W`, 16, width of each performance counter

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `pcWrite`  in  1  1 = PC may advance, 0 = hold PC
- `write_IFID`  in  1  1 = IF/ID captures a new instruction, 0 = hold
- `mux_IDEX`  in  1  1 = pass decoded control into ID/EX, 0 = insert bubble
- `branchTaken_EX`  in  1  EX-stage redirect; flushes the younger stages
- `branchTarget_EX`  in  XLEN  redirect target, valid when `branchTaken_EX`=1
- `instr_IM`  in  32  instruction memory read data for address `pc_IF`
- `ctrl_ID`  in  CTRL_W  decoded control for the instruction in IF/ID
- `pc_IF`  out  XLEN  current fetch address
- `pc_IFID`, `instr_IFID`, `valid_IFID`  out  XLEN/32/1  IF/ID register contents
- `pc_IDEX`, `ctrl_IDEX`, `valid_IDEX`  out  XLEN/CTRL_W/1  ID/EX register contents
- `stallCount`  out  CNT_W  saturating count of stall cycles
- `flushCount`  out  CNT_W  saturating count of redirects

## Operation
All outputs are registers. There is no combinational path from any input to any output.

Priority in every stage: `reset` > `branchTaken_EX` > the hazard controls.

PC:
- reset → `RESET_PC`
- `branchTaken_EX`=1 → `branchTarget_EX`, regardless of `pcWrite`
- `pcWrite`=1 → `pc_IF + 4`, modulo 2^XLEN (wraps from all-ones−3 to 0)
- otherwise → hold

IF/ID:
- reset or `branchTaken_EX`=1 → `instr_IFID`=0x00000013 (NOP), `pc_IFID`=0, `valid_IFID`=0
- `write_IFID`=1 → capture `instr_IM`, `pc_IF`, and set valid=1
- otherwise → hold all three fields

ID/EX:
- reset or `branchTaken_EX`=1 → ctrl=0, pc=0, valid=0
- `mux_IDEX`=0 → bubble: ctrl=0, pc=0, valid=0
- otherwise → `ctrl_IDEX` = `valid_IFID` ? `ctrl_ID` : 0; `pc_IDEX` = `pc_IFID`; `valid_IDEX` = `valid_IFID`

Counters:
- Both reset to 0.
- `stallCount` +1 on each cycle with `pcWrite`=0 and `branchTaken_EX`=0. It holds at 2^CNT_W−1.
- `flushCount` +1 on each cycle with `branchTaken_EX`=1. It saturates the same way.
- A redirect during a stall counts as a flush only.

Hazard inputs are applied independently as given. No consistency check is made between `pcWrite` and `write_IFID`.

## Timing
- Every update takes effect at the rising edge following the cycle in which the inputs are sampled. Latency is 1 cycle per stage.
- Load-use stall (all three controls 0 for one cycle): PC and IF/ID hold for 1 cycle, and exactly one bubble enters ID/EX. Normal flow resumes on the next edge.
- Redirect: `pc_IF` equals the target on the cycle after `branchTaken_EX`. IF/ID and ID/EX are invalid for that cycle. The first target instruction reaches `valid_IFID`=1 one cycle later, provided `write_IFID`=1.
- Back-to-back `branchTaken_EX` on consecutive cycles: each cycle reloads the PC from the latest target and re-flushes both stages.
- Reset mid-stall or mid-redirect: all state returns to reset values on that edge. Hazard and branch inputs in the reset cycle are ignored.
- Reset values: `pc_IF`=`RESET_PC`; `pc_IFID`=0; `instr_IFID`=0x00000013; `valid_IFID`=0; `pc_IDEX`=0; `ctrl_IDEX`=0; `valid_IDEX`=0; both counters 0.

## Test plan
- Reset → 3 cycles free-run with all controls 1 and `instr_IM`=0xA0B0C0D3: `pc_IF` runs 0, 4, 8, 12. `instr_IFID`=0xA0B0C0D3 with `valid_IFID`=1 from cycle 2. Counters stay 0.
- Single load-use stall at `pc_IF`=8: `pc_IF` shows 8 for 2 cycles. IF/ID holds. `valid_IDEX`=0 and `ctrl_IDEX`=0 for one cycle, then resume. `stallCount`=1.
- `branchTaken_EX`=1 with `branchTarget_EX`=0x100 while all hazard controls are 0: next cycle `pc_IF`=0x100, both valids 0, `flushCount`=1, `stallCount` unchanged.
- `pc_IF`=0xFFFFFFFC with `pcWrite`=1 → `pc_IF`=0x00000000.
- CNT_W=4, hold `pcWrite`=0 for 20 cycles → `stallCount` reaches 15 and stays at 15.
- Assert `reset` during a 3-cycle stall with `ctrl_ID`=0xFF → all outputs at reset values on the next edge. Normal fetch from `RESET_PC` resumes after release.

Source files
------------

// File: rtl/fetch_pipe_ctrl.sv
// Front-of-pipe control for the 5-stage RISC-V core: PC, IF/ID and ID/EX registers,
// with load-use stalls, bubbles, EX redirect flushes and saturating perf counters.
module fetch_pipe_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CTRL_W   = 8,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pcWrite,
    input  logic              write_IFID,
    input  logic              mux_IDEX,
    input  logic              branchTaken_EX,
    input  logic [XLEN-1:0]   branchTarget_EX,
    input  logic [31:0]       instr_IM,
    input  logic [CTRL_W-1:0] ctrl_ID,
    output logic [XLEN-1:0]   pc_IF,
    output logic [XLEN-1:0]   pc_IFID,
    output logic [31:0]       instr_IFID,
    output logic              valid_IFID,
    output logic [XLEN-1:0]   pc_IDEX,
    output logic [CTRL_W-1:0] ctrl_IDEX,
    output logic              valid_IDEX,
    output logic [CNT_W-1:0]  stallCount,
    output logic [CNT_W-1:0]  flushCount
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Index 0 counts stall cycles, index 1 counts redirects; a redirect during a stall is a flush only.
    logic [1:0]           countEvent;
    logic [2*CNT_W-1:0]   countFlat;

    assign countEvent = {branchTaken_EX, ~pcWrite & ~branchTaken_EX};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_IF <= RESET_PC;
        end else if (branchTaken_EX) begin
            pc_IF <= branchTarget_EX;
        end else if (pcWrite) begin
            pc_IF <= pc_IF + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || branchTaken_EX) begin
            pc_IFID    <= '0;
            instr_IFID <= NOP_INSTR;
            valid_IFID <= 1'b0;
        end else if (write_IFID) begin
            pc_IFID    <= pc_IF;
            instr_IFID <= instr_IM;
            valid_IFID <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || branchTaken_EX || !mux_IDEX) begin
            pc_IDEX    <= '0;
            ctrl_IDEX  <= '0;
            valid_IDEX <= 1'b0;
        end else begin
            pc_IDEX    <= pc_IFID;
            ctrl_IDEX  <= valid_IFID ? ctrl_ID : '0;
            valid_IDEX <= valid_IFID;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : genCounter
            logic [CNT_W-1:0] countReg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    countReg <= '0;
                end else if (countEvent[gi] && (countReg != {CNT_W{1'b1}})) begin
                    countReg <= countReg + CNT_W'(1);
                end
            end

            assign countFlat[gi*CNT_W +: CNT_W] = countReg;
        end
    endgenerate

    assign stallCount = countFlat[0 +: CNT_W];
    assign flushCount = countFlat[CNT_W +: CNT_W];

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Self-checking bench for fetch_pipe_ctrl: directed test-plan scenarios followed by
// randomized traffic, all compared against a behavioural model of the pipe front.
module tb_fetch_pipe_ctrl;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              pcWrite, write_IFID, mux_IDEX, branchTaken_EX;
    logic [XLEN-1:0]   branchTarget_EX;
    logic [31:0]       instr_IM;
    logic [CTRL_W-1:0] ctrl_ID;
    logic [XLEN-1:0]   pc_IF, pc_IFID, pc_IDEX;
    logic [31:0]       instr_IFID;
    logic              valid_IFID, valid_IDEX;
    logic [CTRL_W-1:0] ctrl_IDEX;
    logic [CNT_W-1:0]  stallCount, flushCount;

    fetch_pipe_ctrl #(
        .XLEN(XLEN), .RESET_PC('0), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .pcWrite(pcWrite), .write_IFID(write_IFID),
        .mux_IDEX(mux_IDEX), .branchTaken_EX(branchTaken_EX),
        .branchTarget_EX(branchTarget_EX), .instr_IM(instr_IM), .ctrl_ID(ctrl_ID),
        .pc_IF(pc_IF), .pc_IFID(pc_IFID), .instr_IFID(instr_IFID), .valid_IFID(valid_IFID),
        .pc_IDEX(pc_IDEX), .ctrl_IDEX(ctrl_IDEX), .valid_IDEX(valid_IDEX),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural picture of the pipe front as the bench understands it.
    logic [31:0] mPc, mPcIfid, mInstrIfid, mPcIdex;
    logic        mValidIfid, mValidIdex;
    logic [7:0]  mCtrlIdex;
    int          mStall, mFlush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int satInc(input int v);
        return (v + 1 > CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic modelStep();
        logic [31:0] oldPc, oldPcIfid;
        logic        oldValidIfid;
        oldPc        = mPc;
        oldPcIfid    = mPcIfid;
        oldValidIfid = mValidIfid;
        if (reset) begin
            mPc = 32'h0; mPcIfid = 32'h0; mInstrIfid = 32'h13; mValidIfid = 1'b0;
            mPcIdex = 32'h0; mCtrlIdex = 8'h0; mValidIdex = 1'b0;
            mStall = 0; mFlush = 0;
        end else if (branchTaken_EX) begin
            // A redirect wipes both younger stages and only ever bumps the flush counter.
            mPc = branchTarget_EX;
            mPcIfid = 32'h0; mInstrIfid = 32'h13; mValidIfid = 1'b0;
            mPcIdex = 32'h0; mCtrlIdex = 8'h0; mValidIdex = 1'b0;
            mFlush = satInc(mFlush);
        end else begin
            if (pcWrite) mPc = oldPc + 32'd4;
            else         mStall = satInc(mStall);
            if (write_IFID) begin
                mPcIfid = oldPc; mInstrIfid = instr_IM; mValidIfid = 1'b1;
            end
            if (mux_IDEX) begin
                mPcIdex    = oldPcIfid;
                mValidIdex = oldValidIfid;
                mCtrlIdex  = oldValidIfid ? ctrl_ID : 8'h0;
            end else begin
                mPcIdex = 32'h0; mCtrlIdex = 8'h0; mValidIdex = 1'b0;
            end
        end
    endtask

    task automatic compareAll(input int cyc);
        string sfx;
        sfx = $sformatf("@%0d", cyc);
        check({"pc_IF", sfx}, 64'(pc_IF), 64'(mPc));
        check({"pc_IFID", sfx}, 64'(pc_IFID), 64'(mPcIfid));
        check({"instr_IFID", sfx}, 64'(instr_IFID), 64'(mInstrIfid));
        check({"valid_IFID", sfx}, 64'(valid_IFID), 64'(mValidIfid));
        check({"pc_IDEX", sfx}, 64'(pc_IDEX), 64'(mPcIdex));
        check({"ctrl_IDEX", sfx}, 64'(ctrl_IDEX), 64'(mCtrlIdex));
        check({"valid_IDEX", sfx}, 64'(valid_IDEX), 64'(mValidIdex));
        check({"stallCount", sfx}, 64'(stallCount), 64'(mStall));
        check({"flushCount", sfx}, 64'(flushCount), 64'(mFlush));
    endtask

    int cycleNum = 0;

    // Drive one cycle of inputs, clock it, then compare every output against the model.
    task automatic step(input logic r, input logic pw, input logic wi, input logic mx,
                        input logic bt, input logic [31:0] tgt, input logic [31:0] ins,
                        input logic [7:0] ctl);
        reset = r; pcWrite = pw; write_IFID = wi; mux_IDEX = mx;
        branchTaken_EX = bt; branchTarget_EX = tgt; instr_IM = ins; ctrl_ID = ctl;
        @(posedge clk);
        modelStep();
        #1;
        cycleNum++;
        $display("cyc %0d r=%0b pw=%0b wi=%0b mx=%0b bt=%0b tgt=%08h | pc=%08h ifid=%08h/%08h/%0b idex=%08h/%02h/%0b st=%0d fl=%0d",
                 cycleNum, r, pw, wi, mx, bt, tgt, pc_IF, pc_IFID, instr_IFID, valid_IFID,
                 pc_IDEX, ctrl_IDEX, valid_IDEX, stallCount, flushCount);
        compareAll(cycleNum);
    endtask

    initial begin
        logic [31:0] stallInstr;
        mPc = 'x; mPcIfid = 'x; mInstrIfid = 'x; mPcIdex = 'x;
        mValidIfid = 1'bx; mValidIdex = 1'bx; mCtrlIdex = 'x; mStall = 0; mFlush = 0;
        reset = 1'b1; pcWrite = 1'b1; write_IFID = 1'b1; mux_IDEX = 1'b1;
        branchTaken_EX = 1'b0; branchTarget_EX = '0; instr_IM = '0; ctrl_ID = '0;
        @(negedge clk);

        // Reset with hostile inputs must still land on reset values.
        step(1, 1, 1, 1, 1, 32'h0000_0400, 32'hDEAD_BEEF, 8'hAA);
        check("reset_pc", 64'(pc_IF), 64'h0);
        check("reset_nop", 64'(instr_IFID), 64'h13);

        // Free run.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 32'hA0B0C0D3, 8'h5A);
        check("freerun_pc", 64'(pc_IF), 64'd12);
        check("freerun_instr", 64'(instr_IFID), 64'hA0B0C0D3);
        check("freerun_valid", 64'(valid_IFID), 64'd1);
        check("freerun_stall", 64'(stallCount), 64'd0);

        // Single load-use stall at pc 8.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 32'h1111_0013, 8'h21);
        step(0, 1, 1, 1, 0, 0, 32'h2222_0013, 8'h22);
        stallInstr = instr_IFID;
        step(0, 0, 0, 0, 0, 0, 32'h3333_0013, 8'h23);
        check("stall_pc_hold", 64'(pc_IF), 64'd8);
        check("stall_ifid_hold", 64'(instr_IFID), 64'(stallInstr));
        check("stall_bubble_valid", 64'(valid_IDEX), 64'd0);
        check("stall_bubble_ctrl", 64'(ctrl_IDEX), 64'd0);
        check("stall_count", 64'(stallCount), 64'd1);
        step(0, 1, 1, 1, 0, 0, 32'h3333_0013, 8'h24);
        check("stall_resume_pc", 64'(pc_IF), 64'd12);
        check("stall_resume_valid", 64'(valid_IDEX), 64'd1);

        // Redirect while all hazard controls are low.
        step(0, 0, 0, 0, 1, 32'h0000_0100, 0, 0);
        check("redir_pc", 64'(pc_IF), 64'h100);
        check("redir_valid_ifid", 64'(valid_IFID), 64'd0);
        check("redir_valid_idex", 64'(valid_IDEX), 64'd0);
        check("redir_flush", 64'(flushCount), 64'd1);
        check("redir_stall", 64'(stallCount), 64'd1);
        // Back-to-back redirects, then first target instruction lands.
        step(0, 1, 1, 1, 1, 32'h0000_0200, 0, 0);
        step(0, 1, 1, 1, 0, 0, 32'hCAFE_0013, 8'h31);
        check("redir_target_ifid_pc", 64'(pc_IFID), 64'h200);
        check("redir_target_valid", 64'(valid_IFID), 64'd1);

        // PC wraparound.
        step(0, 1, 1, 1, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 1, 1, 1, 0, 0, 32'h0000_0013, 8'h01);
        check("wrap_pc", 64'(pc_IF), 64'h0);

        // Counter saturation at CNT_W=4.
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0, 0, 32'h4444_0013, 8'h41);
        check("sat_stall", 64'(stallCount), 64'(CNT_MAX));
        for (int i = 0; i < 18; i++) step(0, 1, 1, 1, 1, 32'(i * 8), 0, 0);
        check("sat_flush", 64'(flushCount), 64'(CNT_MAX));

        // Reset mid-stall with a loud ctrl_ID, then resume from RESET_PC.
        step(0, 1, 1, 1, 0, 0, 32'h5555_0013, 8'hFF);
        step(0, 0, 0, 0, 0, 0, 32'h5555_0013, 8'hFF);
        step(0, 0, 0, 0, 0, 0, 32'h5555_0013, 8'hFF);
        step(1, 0, 0, 0, 0, 0, 32'h5555_0013, 8'hFF);
        check("midstall_reset_pc", 64'(pc_IF), 64'h0);
        check("midstall_reset_ctrl", 64'(ctrl_IDEX), 64'h0);
        check("midstall_reset_stall", 64'(stallCount), 64'h0);
        step(0, 1, 1, 1, 0, 0, 32'h6666_0013, 8'hFF);
        step(0, 1, 1, 1, 0, 0, 32'h6666_0013, 8'hFF);
        check("resume_pc", 64'(pc_IF), 64'd8);

        // Randomized traffic with occasional resets so the small counters keep moving.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
                 $urandom() & 32'hFFFF_FFFC, $urandom(), 8'($urandom()));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checkCount, errorCount);
        $fatal(1, "timeout");
    end
endmodule
